seq_det_sched: RTL
==================

# seq_det_sched

Round-robin scheduler that time-shares one 3-state "1-then-0" sequence-detector datapath among NCH bit-serial requesters. Each channel's detector state is kept as a 2-bit context. The shared next-state logic serves one granted channel per cycle. The block sits between the per-channel bit sources and downstream event logic, and produces per-channel detect levels, a pulsed event stream and a saturating event total.

## Interface
- NCH, 4: number of requesting channels (2..8)
- CNTW, 8: width of evt_total
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  reset, synchronous, active-high
- ch_en  input  NCH  per-channel enable; disabled channels are never granted
- bit_vld  input  NCH  channel has a bit to deliver
- bit_val  input  NCH  bit value per channel, sampled only when granted
- bit_rdy  output  NCH  one-hot grant; a transfer occurs when bit_vld[i] & bit_rdy[i]
- det_out  output  NCH  registered; 1 when the channel context is S2
- evt_vld  output  1  registered one-cycle pulse on a detect event
- evt_ch  output  clog2(NCH)  channel of the current event; valid only with evt_vld
- evt_total  output  CNTW  saturating count of detect events

## Operation
- Context encoding per channel: S0=0 (idle), S1=1 (seen 1), S2=2 (seen 1 then 0). Value 3 is illegal and is treated as S0.
- Next-state rules for the granted channel, applied to bit_val:
  - S0: 1→S1, 0→S0
  - S1: 1→S1, 0→S2
  - S2: 1→S0, 0→S2
- Only the granted channel's context changes in a cycle. All other contexts hold.
- Event: the granted channel goes S1→S2.
  - evt_vld=1 and evt_ch=channel in the next cycle.
  - evt_total increments by 1, saturating at 2^CNTW−1.
  - Remaining in S2 produces no further events.
- Arbitration:
  - A round-robin pointer ptr starts at 0.
  - Eligible channels satisfy bit_vld[i] & ch_en[i].
  - The grant goes to the first eligible channel searching ptr, ptr+1, … mod NCH.
  - On a grant to channel g, ptr ← (g+1) mod NCH. With no grant, ptr holds.
- bit_rdy is combinational from bit_vld, ch_en and ptr. At most one bit is set.
- ch_en[i]=0 forces context i to S0 at the next edge. det_out[i] reads 0 one cycle later, i.e. two edges after ch_en falls. No event is generated by the forced transition.
- det_out[i] is a registered decode of context i (state==S2).

## Timing
- Reset, synchronous and active-high. At the first edge with RST=1:
  - all contexts S0, ptr=0
  - det_out=0, evt_vld=0, evt_ch=0, evt_total=0
- bit_rdy is forced to 0 combinationally while RST=1.
- Reset mid-operation: contexts are discarded and pending events are lost. The first grant after release goes to the lowest eligible channel.
- Latency for a transfer in cycle t:
  - context updates at edge t+1
  - evt_vld/evt_ch visible in cycle t+1
  - det_out visible in cycle t+2
- Throughput is one bit per cycle total. With all NCH channels requesting, each channel is served every NCH cycles.
- bit_vld may drop without a transfer. Nothing is latched unless granted.
- If ch_en[i] falls in the same cycle channel i would have been eligible, there is no grant and context i clears.
- evt_vld is never high in two consecutive cycles for the same channel. Back-to-back events from different channels are allowed.
- Saturation: at 2^CNTW−1, further events still pulse evt_vld but evt_total holds.

## Test plan
- Reset: hold RST 2 cycles with all bit_vld=1.
  - Required: bit_rdy=0, det_out=0, evt_vld=0, evt_total=0.
  - After release, the first grant is ch0.
- Single channel: ch_en=4'b0001, ch0 delivers 1,0,0,1.
  - evt_vld=1 with evt_ch=0 one cycle after the second transfer, and only then.
  - det_out[0]=1 until two cycles after the fourth transfer.
  - evt_total=1.
- Fairness: all bit_vld=1 and ch_en=4'b1111 for 8 cycles.
  - Grants are ch0,1,2,3,0,1,2,3.
  - Then drop bit_vld[1]: the sequence becomes 0,2,3,0.
- Context isolation: ch1 sends 1, ch2 sends 0, ch1 sends 0, interleaved.
  - Exactly one event, evt_ch=1.
  - det_out=4'b0010, and ch2 stays in S0.
- Enable drop: bring ch0 to S1, deassert ch_en[0] for 1 cycle, re-enable, send 0.
  - No event; det_out[0] stays 0.
- Saturation with CNTW=2: generate 5 events on ch3.
  - evt_total reaches 3 and holds.
  - evt_vld pulses 5 times.

Source files
------------

// File: rtl/seq_det_sched_if.sv
// Bit-serial request/grant bundle between NCH bit sources and the shared detector.
// The source side drives valid/value; the scheduler answers with a one-hot ready.
interface seq_det_sched_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] bit_vld;
    logic [NCH-1:0] bit_val;
    logic [NCH-1:0] bit_rdy;

    modport master (output bit_vld, output bit_val, input  bit_rdy);
    modport slave  (input  bit_vld, input  bit_val, output bit_rdy);
endinterface

// File: rtl/seq_det_sched.sv
// Round-robin time-shared "1-then-0" detector: one next-state datapath serves one
// granted channel per cycle, with per-channel 2-bit contexts, detect levels and events.
module seq_det_sched #(
    parameter int NCH  = 4,
    parameter int CNTW = 8,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NCH-1:0]    i_ch_en,
    seq_det_sched_if.slave    bus,
    output logic [NCH-1:0]    o_det_out,
    output logic              o_evt_vld,
    output logic [CHW-1:0]    o_evt_ch,
    output logic [CNTW-1:0]   o_evt_total
);
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;

    logic [1:0]       r_ctx [NCH];
    logic [CHW-1:0]   r_ptr;
    logic [NCH-1:0]   r_det_out;
    logic             r_evt_vld;
    logic [CHW-1:0]   r_evt_ch;
    logic [CNTW-1:0]  r_evt_total;

    logic [NCH-1:0]   w_elig;
    logic [2*NCH-1:0] w_rot;
    logic             w_found;
    logic [CHW:0]     w_sum;
    logic [CHW-1:0]   w_gnt;
    logic [CHW-1:0]   w_ptr_nxt;
    logic [1:0]       w_cur;
    logic             w_bit;
    logic [1:0]       w_next;
    logic             w_event;

    assign w_elig = bus.bit_vld & i_ch_en;

    // Rotate the eligible mask so position k is channel ptr+k; the first set bit wins.
    // NOTE: every variable assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rot   = {w_elig, w_elig} >> r_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = (CHW+1)'(r_ptr) + (CHW+1)'(k);
            end
        end
        w_gnt = (w_sum >= (CHW+1)'(NCH)) ? CHW'(w_sum - (CHW+1)'(NCH)) : CHW'(w_sum);
    end

    assign w_ptr_nxt   = (w_gnt == CHW'(NCH - 1)) ? '0 : w_gnt + 1'b1;
    assign bus.bit_rdy = (w_found && !i_rst) ? (NCH'(1) << w_gnt) : '0;

    assign w_cur = r_ctx[w_gnt];
    assign w_bit = bus.bit_val[w_gnt];

    // The illegal encoding 3 falls into the default arm and behaves as S0.
    always_comb begin
        case (w_cur)
            S1:      w_next = w_bit ? S1 : S2;
            S2:      w_next = w_bit ? S0 : S2;
            default: w_next = w_bit ? S1 : S0;
        endcase
    end

    assign w_event = w_found && (w_cur == S1) && !w_bit;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the context array is reset element by element because a reset
            // must discard every channel's progress, not just the visible outputs.
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= S0;
            end
            r_ptr       <= '0;
            r_det_out   <= '0;
            r_evt_vld   <= 1'b0;
            r_evt_ch    <= '0;
            r_evt_total <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_det_out[i] <= (r_ctx[i] == S2);
                if (!i_ch_en[i]) begin
                    r_ctx[i] <= S0;
                end else if (w_found && (w_gnt == CHW'(i))) begin
                    r_ctx[i] <= w_next;
                end
            end
            if (w_found) begin
                r_ptr <= w_ptr_nxt;
            end
            r_evt_vld <= w_event;
            if (w_event) begin
                r_evt_ch <= w_gnt;
                if (r_evt_total != '1) begin
                    r_evt_total <= r_evt_total + 1'b1;
                end
            end
        end
    end

    assign o_det_out   = r_det_out;
    assign o_evt_vld   = r_evt_vld;
    assign o_evt_ch    = r_evt_ch;
    assign o_evt_total = r_evt_total;
endmodule
